// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling with a bit-period counter,
// one-cycle byte_valid / frame_err pulses. Frames with one or more stop bits are accepted.
//
//   state | meaning
//   IDLE  | line high, waiting for a falling edge on the synchronized line
//   START | counting to the start-bit midpoint to reject glitches
//   DATA  | sampling 8 data bits LSB first, one per bit period
//   STOP  | sampling the stop bit; good stop publishes the byte
//   BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_in,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int N  = CLKS_PER_BIT;
   localparam int CW = $clog2(N);

   localparam logic [CW-1:0] CNT_MID = CW'(H - 1);
   localparam logic [CW-1:0] CNT_END = CW'(N - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic          sync1_q, sync2_q;
   logic          rx_s;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   assign rx_s = sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == CNT_MID) begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  cnt_d   = '0;
                  idx_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_END) begin
               shift_d[idx_q] = rx_s;
               cnt_d          = '0;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_END) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_BREAK: begin
            // A low line here is the tail of the bad frame, never a new start bit.
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= bit_in;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, checked against a
// queue of expected pulses whose times follow from the frame start time.
module tb_uart_rx;

   localparam int N = 16;
   localparam int H = N / 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bit_in;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] b;
      bit         err;
      int         t;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] last_good = 8'h00;

   uart_rx #(.CLKS_PER_BIT(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_in     (bit_in),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Pulse monitor: every pulse must match the oldest expected frame result.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (byte_valid && frame_err) chk("both_pulse", 1, 0);
         if (expq.size() > 0 && expq[0].t < cyc && !(byte_valid || frame_err)) begin
            chk("missing_pulse", cyc, expq[0].t);
            void'(expq.pop_front());
         end
         if (byte_valid || frame_err) begin
            if (expq.size() == 0) begin
               chk("unexp_pulse", {31'd0, byte_valid}, 0);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("kind_err", {31'd0, frame_err}, {31'd0, e.err});
               chk("time", cyc, e.t);
               if (byte_valid) begin
                  chk("byte", {24'd0, byte_out}, {24'd0, e.b});
                  chk("busy_after_good", {31'd0, busy}, 0);
                  last_good = e.b;
               end else begin
                  chk("hold_on_err", {24'd0, byte_out}, {24'd0, last_good});
                  chk("busy_on_err", {31'd0, busy}, 1);
               end
            end
         end
      end
   end

   // All drive tasks start and end on a falling clock edge.
   task automatic drive_bit(input logic v);
      bit_in = v;
      repeat (N) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int nstop, input bit bad_stop);
      exp_t e;
      e.b   = b;
      e.err = bad_stop;
      // edge 0 is the next rising edge; result visible after edge 2+H+9N
      e.t   = cyc + 1 + 2 + H + 9 * N;
      expq.push_back(e);
      drive_bit(1'b0);
      for (int k = 0; k < 8; k++) drive_bit(b[k]);
      if (bad_stop) begin
         drive_bit(1'b0);
         drive_bit(1'b0);
         bit_in = 1'b1;
         repeat (2) @(negedge clk);
         chk("busy_in_break", {31'd0, busy}, 1);
         @(negedge clk);
         chk("busy_break_exit", {31'd0, busy}, 0);
         repeat (N - 3) @(negedge clk);
      end else begin
         for (int s = 0; s < nstop; s++) drive_bit(1'b1);
      end
   endtask

   task automatic idle(input int n);
      bit_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      logic [7:0] b;
      int nst, gap;
      bit bad;

      rst_n  = 1'b0;
      bit_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_byte", {24'd0, byte_out}, 0);
      chk("rst_valid", {31'd0, byte_valid}, 0);
      chk("rst_ferr", {31'd0, frame_err}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      rst_n = 1'b1;
      idle(2 * N);

      send_frame(8'hA5, 1, 1'b0);
      idle(N);

      // glitch: 4 low clocks must be rejected at the start midpoint
      busy_cnt = 0;
      bit_in = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 4) bit_in = 1'b1;
         if (busy) busy_cnt++;
      end
      chk("glitch_busy_cycles", busy_cnt, H);
      chk("glitch_byte_hold", {24'd0, byte_out}, 8'hA5);

      send_frame(8'h3C, 1, 1'b1);
      chk("err_byte_hold", {24'd0, byte_out}, 8'hA5);
      send_frame(8'h3C, 1, 1'b0);
      idle(N);

      send_frame(8'h00, 1, 1'b0);
      send_frame(8'hFF, 1, 1'b0);
      send_frame(8'h55, 1, 1'b0);
      idle(N);

      // reset in the middle of data bit 4 of 0x81; no pulse may follow
      b = 8'h81;
      drive_bit(1'b0);
      for (int k = 0; k < 4; k++) drive_bit(b[k]);
      bit_in = b[4];
      repeat (H) @(negedge clk);
      bit_in = 1'b1;
      rst_n  = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      last_good = 8'h00;
      chk("midrst_byte", {24'd0, byte_out}, 0);
      chk("midrst_valid", {31'd0, byte_valid}, 0);
      chk("midrst_ferr", {31'd0, frame_err}, 0);
      chk("midrst_busy", {31'd0, busy}, 0);
      idle(6 * N);
      send_frame(8'h81, 1, 1'b0);
      idle(N);

      send_frame(8'h00, 2, 1'b0);
      send_frame(8'h5A, 2, 1'b0);
      send_frame(8'hFF, 2, 1'b0);
      idle(N);

      for (int f = 0; f < 24; f++) begin
         b   = 8'($urandom_range(0, 255));
         nst = $urandom_range(1, 2);
         bad = ($urandom_range(0, 4) == 0);
         gap = $urandom_range(0, N);
         send_frame(b, nst, bad);
         idle(gap);
      end

      idle(3 * N);
      chk("drain", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
